sweep_ctrl_7458: RTL

Self-test sequencer for the _7458 dual AND-OR gate core.
- On a start request it drives all 1024 input combinations (6-bit p1 group, 4-bit p2 group) into the core.
- Waits a programmable settle time per vector, then samples p1y/p2y and compares them against an internal golden model.
- Reports pass/fail, mismatch count and first failing vector. Sits between a test/CSR master and one _7458 instance.

---
 rtl/sweep_ctrl_7458.sv | 115 +++++++++++
 1 files changed

// File: rtl/sweep_ctrl_7458.sv
// sweep_ctrl_7458: exhaustive self-test sequencer for a _7458 dual AND-OR gate core
//   clk, rst                       clock, async active-high reset
//   start, abort                   sweep control from the test/CSR master
//   p1_drv[5:0], p2_drv[3:0]       registered vector drives to the core
//   p1y_in, p2y_in                 core outputs under test
//   busy, done, pass               sweep status; done is a one-cycle pulse
//   err_cnt, first_err_vec/_valid  saturating mismatch count and first failing vector
module sweep_ctrl_7458 #(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [5:0]       p1_drv,
    output logic [3:0]       p2_drv,
    input  logic             p1y_in,
    input  logic             p2y_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [9:0]       first_err_vec,
    output logic             first_err_valid
);
    typedef enum logic [1:0] {IDLE, SETTLE_S, SAMPLE, DONE} state_t;
    localparam logic [7:0] T_LOAD = 8'(SETTLE - 1);
    state_t           state_q, state_d;
    logic [9:0]       vec_q, vec_d, fev_q, fev_d;
    logic [7:0]       timer_q, timer_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             fval_q, fval_d, pass_q, pass_d;
    logic             exp1, exp2, mism;
    assign exp1 = (vec_q[0] & vec_q[1] & vec_q[2]) | (vec_q[3] & vec_q[4] & vec_q[5]);
    assign exp2 = (vec_q[6] & vec_q[7]) | (vec_q[8] & vec_q[9]);
    assign mism = (p1y_in != exp1) || (p2y_in != exp2);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            timer_q <= '0;
            err_q   <= '0;
            fev_q   <= '0;
            fval_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fval_q  <= fval_d;
            pass_q  <= pass_d;
        end
    end
    // vec is zeroed on every exit from the sweep, so the drives can come straight from it
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        timer_d = timer_q;
        err_d   = err_q;
        fev_d   = fev_q;
        fval_d  = fval_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: if (start && !abort) begin
                state_d = SETTLE_S;
                vec_d   = '0;
                err_d   = '0;
                fval_d  = 1'b0;
                pass_d  = 1'b0;
                timer_d = T_LOAD;
            end
            SETTLE_S: begin
                if (abort) begin
                    state_d = IDLE;
                    vec_d   = '0;
                end else if (timer_q == 8'd0) state_d = SAMPLE;
                else timer_d = timer_q - 8'd1;
            end
            SAMPLE: begin
                // an aborted sample still records its result
                if (mism) begin
                    err_d = (err_q == '1) ? err_q : err_q + CNT_W'(1);
                    if (!fval_q) begin
                        fev_d  = vec_q;
                        fval_d = 1'b1;
                    end
                end
                if (abort || vec_q == 10'd1023) begin
                    state_d = abort ? IDLE : DONE;
                    vec_d   = '0;
                end else begin
                    state_d = SETTLE_S;
                    vec_d   = vec_q + 10'd1;
                    timer_d = T_LOAD;
                end
            end
            DONE: begin
                state_d = IDLE;
                pass_d  = (err_q == '0);
            end
            default: state_d = IDLE;
        endcase
    end
    assign busy            = (state_q == SETTLE_S) || (state_q == SAMPLE);
    assign done            = (state_q == DONE);
    assign p1_drv          = vec_q[5:0];
    assign p2_drv          = vec_q[9:6];
    assign pass            = pass_q;
    assign err_cnt         = err_q;
    assign first_err_vec   = fev_q;
    assign first_err_valid = fval_q;
endmodule
